dt_req_injector: RTL
====================

// Module: dt_req_injector
// PURPOSE
//  Source-side initiator for the 4-in/5-out DT router: buffers packets from a local producer and drives one router input port.
//  Drives req_out = {valid, dest[2:0], data[15:0]} and holds the packet until the router returns ack.
//  Retries lost arbitration; drops undeliverable packets.
//  One instance per router input (in_n0..in_n3).
//  Its instance index sets its fixed arbitration priority (n0 highest).
// PARAMETERS
//  DEPTH        4   packet FIFO entries (power of 2, >=2)
//  MAX_RETRY    15  consecutive nacks before drop; 0 = retry forever
//  BACKOFF_CYC  2   idle cycles after a nack (only with DT_INJ_BACKOFF_EN)
// PORTS
//  clk          in   1   clock, all state on rising edge
//  rst_n        in   1   synchronous, active-low reset
//  push_valid   in   1   producer offers packet
//  push_ready   out  1   FIFO not full; transfer when push_valid & push_ready
//  push_dest    in   3   destination output 0..4
//  push_data    in   16  payload
//  req_out      out  20  to router in_nX: {valid, dest, data}
//  ack_in       in   1   router ack_nX, combinational from req_out, same cycle
//  sent         out  1   1-cycle pulse: head packet accepted by router
//  dropped      out  1   1-cycle pulse: head packet discarded
//  fifo_count   out  $clog2(DEPTH)+1  occupied entries
// BEHAVIOUR
//  Reset: FIFO flushed, state IDLE, retry_cnt=0.
//   Outputs during reset: req_out=20'b0, push_ready=0, sent=0, dropped=0, fifo_count=0.
//   push_ready rises the cycle after rst_n deasserts.
//  Reset mid-operation: in-flight and queued packets are lost, with no sent/dropped pulse.
//  FSM states: IDLE, REQ, BACKOFF.
//  IDLE -> REQ when fifo_count!=0.
//   Latency: push in cycle t into an empty FIFO -> req_out valid in cycle t+1.
//  REQ: req_out = {1'b1, head.dest, head.data}.
//   ack_in=1 at edge: pop, sent=1, retry_cnt=0.
//    Next state is REQ if more packets are queued, else IDLE.
//    Back-to-back packets therefore issue on consecutive cycles.
//   ack_in=0 at edge: retry_cnt++.
//    If MAX_RETRY!=0 and retry_cnt+1==MAX_RETRY: pop, dropped=1, retry_cnt=0.
//    Otherwise stay in REQ, or go to BACKOFF if DT_INJ_BACKOFF_EN is defined.
//  Invalid dest (5..7) at head: never presented (req_out=0).
//   Popped with dropped=1 in the first cycle it is head, without the retry count.
//  IDLE/BACKOFF: req_out=20'b0. ack_in is ignored whenever req_out[19]=0.
//  req_out and packet data are stable while in REQ; the head never changes until pop.
//  FIFO full: push_ready=0 even if a pop happens the same cycle. No bypass path.
//  Simultaneous push and pop when not full: both happen; count unchanged.
//  fifo_count and retry_cnt saturate logically: no overflow possible by construction.
// CONFIGURATION
//  DT_INJ_BACKOFF_EN defined: after a nack that does not drop, go to BACKOFF.
//   Hold valid low for BACKOFF_CYC cycles via a down-counter, then return to REQ.
//   Lets lower-priority sources win arbitration.
//  Not defined: BACKOFF is unreachable and a nacked packet re-requests the very next cycle.
//   BACKOFF_CYC is ignored.
// STRUCTURE
//  Package dt_pkg holds the shared definitions:
//   typedef struct packed {logic valid; logic [2:0] dest; logic [15:0] data;} dt_req_t
//   typedef struct packed {logic [1:0] cond; logic [15:0] data;} dt_out_t
//   localparam DT_N_OUT=5, DT_COND_OK=2'b01, DT_COND_CONFLICT=2'b10
//   typedef enum logic [1:0] {INJ_IDLE, INJ_REQ, INJ_BACKOFF} dt_inj_state_t
//  Sub-module dt_sync_fifo (WIDTH=19, DEPTH) provides push, pop, head, count and full/empty.
//  FSM, retry counter and backoff counter live in this module.
// TESTING
//  1. Reset, push dest=2 data=16'hBEEF, ack_in tied 1 ->
//     req_out=20'hABEEF in cycle t+1, sent pulse, fifo_count returns 0.
//  2. Push 4 packets (DEPTH=4) with ack low ->
//     push_ready=0 after the 4th push, a 5th push is not accepted, fifo_count=4.
//     Then ack high for 4 cycles -> 4 sent pulses on consecutive cycles.
//  3. MAX_RETRY=3, ack held 0 -> req_out valid for 3 cycles, dropped pulse on the 3rd edge.
//     The next packet is presented without a gap.
//  4. Push dest=5 -> req_out stays 0, dropped pulse 2 cycles after the push, ack ignored.
//  5. DT_INJ_BACKOFF_EN, BACKOFF_CYC=2, one nack then ack ->
//     request pattern valid,0,0,valid, then sent.
//  6. rst_n low for 1 cycle with 3 packets queued and one in REQ ->
//     next cycle req_out=0 and fifo_count=0, no sent/dropped pulse; packets pushed afterwards go out normally.

Source files
------------

// File: rtl/dt_pkg.sv
// Shared definitions for the DT router and its request injectors.
package dt_pkg;

    typedef struct packed {
        logic        valid;
        logic [2:0]  dest;
        logic [15:0] data;
    } dt_req_t;

    typedef struct packed {
        logic [1:0]  cond;
        logic [15:0] data;
    } dt_out_t;

    localparam int         DT_N_OUT         = 5;
    localparam logic [1:0] DT_COND_OK       = 2'b01;
    localparam logic [1:0] DT_COND_CONFLICT = 2'b10;

    typedef enum logic [1:0] {
        INJ_IDLE,
        INJ_REQ,
        INJ_BACKOFF
    } dt_inj_state_t;

    // A destination is routable only if it names one of the router outputs.
    function automatic logic dt_dest_ok(input logic [2:0] dest);
        return dest < 3'(DT_N_OUT);
    endfunction

endpackage

// File: rtl/dt_sync_fifo.sv
// Single-clock FIFO with a combinational head view; pointers flush on reset,
// storage is left uninitialised.
module dt_sync_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       push_data,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/dt_req_injector.sv
// Buffers local packets and drives one DT router input until acked, retrying or dropping.
// Optional feature macro: DT_INJ_BACKOFF_EN (idle gap after each non-dropping nack).
module dt_req_injector
    import dt_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int MAX_RETRY   = 15,
    parameter int BACKOFF_CYC = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_valid,
    output logic                   push_ready,
    input  logic [2:0]             push_dest,
    input  logic [15:0]            push_data,
    output logic [19:0]            req_out,
    input  logic                   ack_in,
    output logic                   sent,
    output logic                   dropped,
    output logic [$clog2(DEPTH):0] fifo_count
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    dt_inj_state_t state_q, state_d;
    logic [RW-1:0] retry_q, retry_d;
    logic          sent_q, sent_d;
    logic          dropped_q, dropped_d;
    logic          ready_q;
    logic          push_fire;
    logic          pop;
    logic [18:0]   head;
    logic [CW-1:0] count;
    logic [CW-1:0] count_after;
    logic          full;
    logic          empty;
    logic          head_ok;
    dt_req_t       req;

`ifdef DT_INJ_BACKOFF_EN
    localparam int BO_W = (BACKOFF_CYC < 2) ? 1 : $clog2(BACKOFF_CYC);
    logic [BO_W-1:0] bo_q, bo_d;
`else
    logic [31:0] unused_backoff_cyc;
    assign unused_backoff_cyc = 32'(BACKOFF_CYC);
`endif

    dt_sync_fifo #(
        .WIDTH (19),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_fire),
        .pop       (pop),
        .push_data ({push_dest, push_data}),
        .head      (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    // ready_q keeps push_ready low through reset and for the first cycle after it.
    assign push_ready = ready_q & ~full;
    assign push_fire  = push_valid & push_ready;
    assign head_ok    = dt_dest_ok(head[18:16]);

    always_comb begin
        req = '0;
        if (state_q == INJ_REQ && !empty && head_ok) begin
            req.valid = 1'b1;
            req.dest  = head[18:16];
            req.data  = head[15:0];
        end
    end

    assign req_out    = req;
    assign sent       = sent_q;
    assign dropped    = dropped_q;
    assign fifo_count = count;

    always_comb begin
        state_d     = state_q;
        retry_d     = retry_q;
        sent_d      = 1'b0;
        dropped_d   = 1'b0;
        pop         = 1'b0;
        count_after = '0;
`ifdef DT_INJ_BACKOFF_EN
        bo_d        = bo_q;
`endif
        case (state_q)
            INJ_IDLE: begin
            end
            INJ_REQ: begin
                if (empty) begin
                    state_d = INJ_IDLE;
                end else if (!head_ok) begin
                    pop       = 1'b1;
                    dropped_d = 1'b1;
                    retry_d   = '0;
                end else if (ack_in) begin
                    pop     = 1'b1;
                    sent_d  = 1'b1;
                    retry_d = '0;
                end else if (MAX_RETRY != 0 &&
                             ({1'b0, retry_q} + 1'b1) == (RW+1)'(MAX_RETRY)) begin
                    pop       = 1'b1;
                    dropped_d = 1'b1;
                    retry_d   = '0;
                end else begin
                    // With MAX_RETRY=0 the counter is never needed, so it stays at zero.
                    if (MAX_RETRY != 0) begin
                        retry_d = retry_q + 1'b1;
                    end
`ifdef DT_INJ_BACKOFF_EN
                    if (BACKOFF_CYC != 0) begin
                        state_d = INJ_BACKOFF;
                        bo_d    = BO_W'(BACKOFF_CYC - 1);
                    end
`endif
                end
            end
            INJ_BACKOFF: begin
`ifdef DT_INJ_BACKOFF_EN
                if (bo_q == '0) begin
                    state_d = INJ_REQ;
                end else begin
                    bo_d = bo_q - 1'b1;
                end
`else
                state_d = INJ_REQ;
`endif
            end
            default: state_d = INJ_IDLE;
        endcase

        // Occupancy after this edge decides whether the next packet issues back-to-back.
        count_after = count + CW'(push_fire) - CW'(pop);
        if (state_q == INJ_IDLE || pop) begin
            state_d = (count_after != '0) ? INJ_REQ : INJ_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= INJ_IDLE;
            retry_q   <= '0;
            sent_q    <= 1'b0;
            dropped_q <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            retry_q   <= retry_d;
            sent_q    <= sent_d;
            dropped_q <= dropped_d;
            ready_q   <= 1'b1;
        end
    end

`ifdef DT_INJ_BACKOFF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bo_q <= '0;
        end else begin
            bo_q <= bo_d;
        end
    end
`endif

endmodule
